apb_completer: RTL and testbench
================================

APB_COMPLETER -- requirements
Module: apb_completer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hDEAD_CAF0, decode base; bits [31:4] compared, [3:2] select register.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, number of wait states inserted per transfer.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have port psel_i, input, 1 bit, APB select.
REQ-006 SHALL have port penable_i, input, 1 bit, APB enable (access phase).
REQ-007 SHALL have port paddr_i, input, 32 bits, APB address.
REQ-008 SHALL have port pwrite_i, input, 1 bit, 1 = write, 0 = read.
REQ-009 SHALL have port pwdata_i, input, 32 bits, write data.
REQ-010 SHALL have port pready_o, output, 1 bit, transfer completes this cycle.
REQ-011 SHALL have port prdata_o, output, 32 bits, read data, valid only while pready_o=1 on a read.
REQ-012 SHALL have port pslverr_o, output, 1 bit, error response, valid only while pready_o=1.

Function
REQ-013 SHALL hold four 32-bit registers: offset 0x0 DATA0 RW, 0x4 DATA1 RW, 0x8 TXN_CNT RO, 0xC DATA3 RW.
REQ-014 SHALL implement FSM IDLE -> ACCESS -> IDLE.
- IDLE: on an edge with psel_i=1, penable_i=0 (setup), go to ACCESS.
- At that edge, latch address, direction and wdata, and load wait counter with WAIT_CYCLES.
REQ-015 In ACCESS with wait counter non-zero, SHALL decrement the counter on each edge where psel_i=1 and penable_i=1.
REQ-016 SHALL drive pready_o=1 exactly when state=ACCESS and wait counter=0, with no combinational path from APB inputs.
- WAIT_CYCLES=0 gives a zero-wait transfer: pready_o=1 in the first access cycle.
REQ-017 SHALL complete the transfer on the edge where state=ACCESS and psel_i=penable_i=pready_o=1.
- Commit the write, if any, on that edge.
- Return to IDLE on that edge.
- pready_o is therefore high for exactly one cycle.
REQ-018 SHALL treat a transfer as an error when:
- latched addr[31:4] differs from BASE_ADDR[31:4], or
- it is a write to TXN_CNT.
An error transfer SHALL set pslverr_o=1 while pready_o=1 and modify no register.
REQ-019 On a successful read, SHALL drive prdata_o with the selected register while pready_o=1.
- prdata_o SHALL be 0 at all other times, including error reads.
REQ-020 SHALL increment TXN_CNT by 1 on every completed transfer (read or write, error or not).
- 32-bit; wraps 0xFFFF_FFFF -> 0 with no flag.
REQ-021 A read of TXN_CNT SHALL return its value before the increment of that same transfer.
REQ-022 SHALL ignore addr[1:0]; unaligned addresses decode by [3:2] with no error (0xDEADCAFE selects DATA3).
REQ-023 If psel_i drops while in ACCESS before completion, SHALL abort to IDLE next edge: no write, no TXN_CNT increment.
REQ-024 In ACCESS with psel_i=1 and penable_i=0, SHALL hold state and counter (protocol violation, no action).
REQ-025 SHALL ignore penable_i=1 in IDLE (no setup seen).

Reset
REQ-026 On reset_n=0, SHALL immediately and asynchronously force:
- state IDLE, wait counter 0;
- DATA0, DATA1, DATA3 and TXN_CNT to 0;
- pready_o=0, pslverr_o=0, prdata_o=0.
REQ-027 Reset asserted mid-transfer SHALL discard the transfer: no register write.
- The first transfer after reset_n rises SHALL require a fresh setup phase.

Verification
REQ-028 Write 0x0000_0005 to 0xDEADCAFE, then read it back (WAIT_CYCLES=2):
- pready_o high in the 3rd access cycle;
- read returns 0x0000_0005, pslverr_o=0.
REQ-029 WAIT_CYCLES=0: write to 0xDEADCAF4, then read it:
- pready_o=1 in the first access cycle;
- value returned matches.
REQ-030 Read 0xDEADCAF8 after 3 completed transfers -> prdata_o=3. A following write to 0xDEADCAF8 -> pslverr_o=1 and TXN_CNT=4.
REQ-031 Read 0x1234_5670 -> pslverr_o=1, prdata_o=0, DATA0..DATA3 unchanged.
REQ-032 Drop psel_i during a wait state of a write of 0xFFFF_FFFF to 0xDEADCAF0 -> DATA0 stays 0, TXN_CNT unchanged.
REQ-033 Pulse reset_n low mid-access -> outputs 0 within the same cycle; all registers 0 afterwards.

Source files
------------

// File: rtl/apb_completer.sv
// apb_completer: APB completer that exposes four 32-bit registers at BASE_ADDR.
//   0x0 DATA0 (RW), 0x4 DATA1 (RW), 0x8 TXN_CNT (RO), 0xC DATA3 (RW)
// Each transfer is stretched by WAIT_CYCLES wait states. Every completed transfer
// increments TXN_CNT, including error transfers.
// Ports:
//   clk, reset_n         - clock and async active-low reset
//   psel_i, penable_i    - APB select and enable
//   paddr_i, pwrite_i,
//   pwdata_i             - APB address, direction, and write data
//   pready_o             - transfer completes this cycle
//   prdata_o             - read data; zero except on a successful read while ready
//   pslverr_o            - error response while ready
module apb_completer #(
  parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CAF0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        setup, complete;

  // Address bits [1:0] take no part in decode.
  logic [31:2] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;

  logic [31:0] data0, data1, data3, txn_cnt;
  logic [1:0]  sel;
  logic        err;
  logic [31:0] rd_mux;

  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^paddr_i[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    setup        = 1'b0;
    complete     = 1'b0;
    case (state)
      IDLE: begin
        // penable_i high without a prior setup phase is ignored.
        if (psel_i && !penable_i) begin
          state_nxt    = ACCESS;
          wait_cnt_nxt = WAIT_INIT;
          setup        = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          // The requester abandoned the transfer, so nothing is committed.
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (penable_i) begin
          if (wait_cnt == 4'd0) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else begin
            wait_cnt_nxt = wait_cnt - 4'd1;
          end
        end
        // psel_i=1 with penable_i=0 is a protocol violation; hold state and counter.
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (setup) begin
      addr_q  <= paddr_i[31:2];
      write_q <= pwrite_i;
      wdata_q <= pwdata_i;
    end
  end

  assign sel = addr_q[3:2];
  assign err = (addr_q[31:4] != BASE_ADDR[31:4]) || (write_q && sel == 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data0   <= '0;
      data1   <= '0;
      data3   <= '0;
      txn_cnt <= '0;
    end else if (complete) begin
      txn_cnt <= txn_cnt + 32'd1;
      if (write_q && !err) begin
        case (sel)
          2'd0:    data0 <= wdata_q;
          2'd1:    data1 <= wdata_q;
          2'd3:    data3 <= wdata_q;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (sel)
      2'd0:    rd_mux = data0;
      2'd1:    rd_mux = data1;
      2'd2:    rd_mux = txn_cnt;   // pre-increment value of this transfer
      default: rd_mux = data3;
    endcase
  end

  // Outputs are decoded only from registered state, so they have no combinational
  // path from the APB inputs, and they drop as soon as reset is asserted.
  assign pready_o  = (state == ACCESS) && (wait_cnt == 4'd0);
  assign pslverr_o = pready_o && err;
  assign prdata_o  = (pready_o && !write_q && !err) ? rd_mux : '0;

endmodule

// File: tb/tb_apb_completer.sv
module tb_apb_completer;

  localparam logic [31:0] BASE = 32'hDEAD_CAF0;

  logic clk = 1'b0;
  logic reset_n;
  logic psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [1:0] pready, pslverr;
  logic [1:0][31:0] prdata;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: index 0 uses WAIT_CYCLES=2, index 1 uses WAIT_CYCLES=0.
  logic [31:0] mreg [2][4];

  always #5 clk = ~clk;

  apb_completer #(.BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset_n(reset_n), .psel_i(psel), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0]));

  apb_completer #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .psel_i(psel), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int wt(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit is_err(logic [31:0] a, logic wr);
    return (a[31:4] != BASE[31:4]) || (wr && a[3:2] == 2'd2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 4; r++) mreg[i][r] = '0;
  endtask

  task automatic chk_quiet(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_rdy%0d", tag, i), 32'(pready[i]), 32'd0);
      chk($sformatf("%s_err%0d", tag, i), 32'(pslverr[i]), 32'd0);
      chk($sformatf("%s_rd%0d", tag, i), prdata[i], 32'd0);
    end
  endtask

  // One APB transfer. abort_at = access cycle in which psel drops (-1 means none).
  // stall inserts a psel=1/penable=0 cycle before the first access cycle.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input int abort_at, input bit stall);
    bit done [2];
    bit rdy  [2];
    bit e;
    logic [1:0] s;
    done[0] = 0; done[1] = 0;
    e = is_err(a, wr);
    s = a[3:2];
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd;
    @(negedge clk);
    if (stall) begin
      #1;
      for (int i = 0; i < 2; i++)
        chk($sformatf("stall_rdy%0d", i), 32'(pready[i]), 32'(wt(i) == 0));
      @(negedge clk);
    end
    for (int k = 0; k <= 2; k++) begin
      if (k == abort_at) begin psel = 1'b0; penable = 1'b0; end
      else penable = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
        rdy[i] = !done[i] && (k == wt(i));
        chk($sformatf("rdy%0d_k%0d", i, k), 32'(pready[i]), 32'(rdy[i]));
        if (rdy[i]) begin
          chk($sformatf("slverr%0d", i), 32'(pslverr[i]), 32'(e));
          chk($sformatf("rdata%0d", i), prdata[i],
              (wr || e) ? 32'd0 : mreg[i][s]);
        end else begin
          chk($sformatf("slverr%0d_idle", i), 32'(pslverr[i]), 32'd0);
          chk($sformatf("rdata%0d_idle", i), prdata[i], 32'd0);
        end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (k == abort_at) done[i] = 1;
        else if (rdy[i]) begin
          done[i] = 1;
          if (wr && !e) mreg[i][s] = wd;
          mreg[i][2] = mreg[i][2] + 32'd1;
        end
      end
      @(negedge clk);
      if (done[0] && done[1]) break;
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rand_xfer();
    logic [31:0] a;
    int ab;
    a = ($urandom_range(0, 9) < 8) ? {BASE[31:4], 4'($urandom)} : $urandom;
    ab = ($urandom_range(0, 99) < 15) ? int'($urandom_range(0, 2)) : -1;
    xfer(a, 1'($urandom), $urandom, ab, $urandom_range(0, 99) < 15);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    #2;
    chk_quiet("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Abort during a wait state: the 2-wait instance keeps DATA0 at 0.
    xfer(BASE | 32'h0, 1'b1, 32'hFFFF_FFFF, 1, 1'b0);
    xfer(BASE | 32'h0, 1'b0, 32'h0, -1, 1'b0);
    xfer(BASE | 32'h8, 1'b0, 32'h0, -1, 1'b0);
    // Unaligned address selects DATA3.
    xfer(32'hDEAD_CAFE, 1'b1, 32'h0000_0005, -1, 1'b0);
    xfer(32'hDEAD_CAFE, 1'b0, 32'h0, -1, 1'b0);
    xfer(32'hDEAD_CAF4, 1'b1, 32'hA5A5_1234, -1, 1'b0);
    xfer(32'hDEAD_CAF4, 1'b0, 32'h0, -1, 1'b1);
    xfer(32'hDEAD_CAF8, 1'b0, 32'h0, -1, 1'b0);
    xfer(32'hDEAD_CAF8, 1'b1, 32'h1111_1111, -1, 1'b0);
    xfer(32'hDEAD_CAF8, 1'b0, 32'h0, -1, 1'b0);
    xfer(32'h1234_5670, 1'b0, 32'h0, -1, 1'b0);
    xfer(32'h1234_5674, 1'b1, 32'hDEAD_BEEF, -1, 1'b0);
    for (int r = 0; r < 4; r++) xfer(BASE | 32'(r * 4), 1'b0, 32'h0, -1, 1'b0);

    // penable without setup in IDLE must not start a transfer.
    @(negedge clk); psel = 1'b1; penable = 1'b1; paddr = BASE;
    @(negedge clk); #1;
    chk_quiet("idle_en");
    psel = 1'b0; penable = 1'b0;

    for (int n = 0; n < 200; n++) rand_xfer();

    // Reset during an access phase.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = BASE | 32'hC; pwrite = 1'b1; pwdata = 32'h7777_7777;
    @(negedge clk); penable = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    model_reset();
    @(negedge clk); psel = 1'b0; penable = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    for (int r = 0; r < 4; r++) xfer(BASE | 32'(r * 4), 1'b0, 32'h0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
